// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic inter-stage pipeline register.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY,
      PS_BUSY,
      PS_FULL
   } ps_state_e;

   localparam int PS_CTRL_W      = 16;
   localparam int PS_DATA_W      = 128;
   localparam int PS_SKID        = 1;
   localparam int PS_STALL_CNT_W = 16;
   localparam int PS_CTRL_MAX_W  = 256;

   function automatic logic [PS_CTRL_MAX_W-1:0] zero_ctrl();
      return '0;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter, shared by the pipeline performance monitors.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int W = PS_STALL_CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready stage register with optional skid slot,
// synchronous flush and a saturating stall counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W      = PS_CTRL_W,
   parameter int DATA_W      = PS_DATA_W,
   parameter int SKID        = PS_SKID,
   parameter int STALL_CNT_W = PS_STALL_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [DATA_W-1:0]      out_data,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   ps_state_e         state_q, state_d;
   logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
   logic [DATA_W-1:0] s_data_q, s_data_d;
   logic              acc;
   logic              emit;

   assign out_valid = (state_q != PS_EMPTY);
   assign acc       = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   // Skid mode decodes ready from state only, so out_ready never reaches in_ready.
   if (SKID != 0) begin : g_skid
      assign in_ready = (state_q != PS_FULL);
   end else begin : g_single
      assign in_ready = ~out_valid | out_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= PS_EMPTY;
         m_ctrl_q <= '0;
         m_data_q <= '0;
         s_ctrl_q <= '0;
         s_data_q <= '0;
      end else begin
         state_q  <= state_d;
         m_ctrl_q <= m_ctrl_d;
         m_data_q <= m_data_d;
         s_ctrl_q <= s_ctrl_d;
         s_data_q <= s_data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      m_ctrl_d = m_ctrl_q;
      m_data_d = m_data_q;
      s_ctrl_d = s_ctrl_q;
      s_data_d = s_data_q;
      if (flush) begin
         state_d = PS_EMPTY;
      end else begin
         unique case (state_q)
            PS_EMPTY: begin
               if (acc) begin
                  state_d  = PS_BUSY;
                  m_ctrl_d = in_ctrl;
                  m_data_d = in_data;
               end
            end
            PS_BUSY: begin
               if (acc && emit) begin
                  m_ctrl_d = in_ctrl;
                  m_data_d = in_data;
               end else if (emit) begin
                  state_d = PS_EMPTY;
               end else if (acc) begin
                  state_d  = PS_FULL;
                  s_ctrl_d = in_ctrl;
                  s_data_d = in_data;
               end
            end
            PS_FULL: begin
               if (emit) begin
                  state_d  = PS_BUSY;
                  m_ctrl_d = s_ctrl_q;
                  m_data_d = s_data_q;
               end
            end
            default: state_d = PS_EMPTY;
         endcase
      end
   end

   always_comb begin
      out_ctrl = out_valid ? m_ctrl_q : CTRL_W'(zero_ctrl());
      out_data = m_data_q;
   end

   sat_counter #(
      .W(STALL_CNT_W)
   ) u_stall (
      .clk  (clk),
      .reset(reset),
      .inc  (out_valid & ~out_ready),
      .cnt  (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid, single-entry and narrow-counter instances.
module tb_pipe_stage_reg;

   localparam int CW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;

   logic          d_ov[3];
   logic          d_ir[3];
   logic [CW-1:0] d_ctrl[3];
   logic [DW-1:0] d_data[3];
   logic [15:0]   d_st[3];
   logic [15:0]   st1, st0;
   logic [3:0]    st4;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .STALL_CNT_W(16)) u1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(d_ir[0]),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(d_ov[0]), .out_ready(out_ready),
      .out_ctrl(d_ctrl[0]), .out_data(d_data[0]), .stall_cnt(st1));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .STALL_CNT_W(16)) u0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(d_ir[1]),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(d_ov[1]), .out_ready(out_ready),
      .out_ctrl(d_ctrl[1]), .out_data(d_data[1]), .stall_cnt(st0));

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .STALL_CNT_W(4)) u4 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(d_ir[2]),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(d_ov[2]), .out_ready(out_ready),
      .out_ctrl(d_ctrl[2]), .out_data(d_data[2]), .stall_cnt(st4));

   assign d_st[0] = st1;
   assign d_st[1] = st0;
   assign d_st[2] = {12'd0, st4};

   // Reference: each stage is an ordered list of up to cap entries.
   int          mcnt[3];
   logic [23:0] mbuf[3][2];
   logic [15:0] mlast[3];
   int          mstall[3];
   int          mskid[3] = '{1, 0, 1};
   int          mmax[3]  = '{65535, 65535, 15};

   function automatic logic exp_ir(int k);
      if (mskid[k] != 0) return mcnt[k] < 2;
      return (mcnt[k] == 0) || out_ready;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_model();
      logic [23:0] f;
      for (int k = 0; k < 3; k++) begin
         f = mbuf[k][0];
         chk($sformatf("d%0d out_valid", k), 32'(d_ov[k]), 32'(mcnt[k] > 0));
         chk($sformatf("d%0d out_ctrl", k), 32'(d_ctrl[k]),
             (mcnt[k] > 0) ? 32'(f[23:16]) : 32'd0);
         chk($sformatf("d%0d out_data", k), 32'(d_data[k]),
             (mcnt[k] > 0) ? 32'(f[15:0]) : 32'(mlast[k]));
         chk($sformatf("d%0d in_ready", k), 32'(d_ir[k]), 32'(exp_ir(k)));
         chk($sformatf("d%0d stall_cnt", k), 32'(d_st[k]), 32'(mstall[k]));
      end
   endtask

   task automatic model_step();
      logic rdy;
      logic [23:0] f;
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            mcnt[k]   = 0;
            mlast[k]  = '0;
            mstall[k] = 0;
         end else begin
            rdy = exp_ir(k);
            if (mcnt[k] > 0 && !out_ready && mstall[k] < mmax[k])
               mstall[k]++;
            if (mcnt[k] > 0 && out_ready) begin
               mbuf[k][0] = mbuf[k][1];
               mcnt[k]--;
            end
            if (flush) begin
               mcnt[k] = 0;
            end else if (in_valid && rdy) begin
               mbuf[k][mcnt[k]] = {in_ctrl, in_data};
               mcnt[k]++;
            end
            if (mcnt[k] > 0) begin
               f = mbuf[k][0];
               mlast[k] = f[15:0];
            end
         end
      end
   endtask

   task automatic drive(input logic iv, input logic ordy, input logic fl,
                        input logic rs, input logic [CW-1:0] c,
                        input logic [DW-1:0] d);
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      reset     = rs;
      in_ctrl   = c;
      in_data   = d;
      #3;
      check_model();
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          ov;
      logic [DW-1:0] od;
      logic          ir;
   } vec_t;

   vec_t tbl[10];

   initial begin
      for (int i = 0; i < 10; i++) begin
         tbl[i].iv = (i < 8);
         tbl[i].d  = DW'(i + 1);
         tbl[i].ov = (i >= 1 && i <= 8);
         tbl[i].od = (i == 0) ? 16'd0 : ((i <= 8) ? DW'(i) : 16'd8);
         tbl[i].ir = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
         mcnt[k] = 0; mlast[k] = '0; mstall[k] = 0;
         mbuf[k][0] = '0; mbuf[k][1] = '0;
      end
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      in_ctrl = 8'h5A; in_data = 16'h1234;
      @(posedge clk);
      #1;

      // reset held a second cycle with traffic offered
      drive(1, 1, 0, 1, 8'h5A, 16'h1234);
      tick();
      drive(0, 1, 0, 0, 8'h00, 16'h0000);
      chk("rst out_valid", 32'(d_ov[0]), 0);
      chk("rst out_ctrl", 32'(d_ctrl[0]), 0);
      chk("rst out_data", 32'(d_data[0]), 0);
      chk("rst stall_cnt", 32'(d_st[0]), 0);
      chk("rst in_ready", 32'(d_ir[0]), 1);
      tick();

      // streaming table
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].iv, 1, 0, 0, CW'(8'h40 + i), tbl[i].d);
         chk($sformatf("stream%0d out_valid", i), 32'(d_ov[0]), 32'(tbl[i].ov));
         chk($sformatf("stream%0d out_data", i), 32'(d_data[0]), 32'(tbl[i].od));
         chk($sformatf("stream%0d in_ready", i), 32'(d_ir[0]), 32'(tbl[i].ir));
         chk($sformatf("stream%0d in_ready skid0", i), 32'(d_ir[1]), 1);
         chk($sformatf("stream%0d stall", i), 32'(d_st[0]), 0);
         tick();
      end

      // backpressure: A, then B into skid, C held upstream
      drive(1, 0, 0, 0, 8'hA1, 16'h00A1); tick();
      drive(1, 0, 0, 0, 8'hB2, 16'h00B2);
      chk("bp A shown", 32'(d_data[0]), 32'h00A1);
      chk("bp skid0 in_ready low", 32'(d_ir[1]), 0);
      tick();
      drive(1, 0, 0, 0, 8'hC3, 16'h00C3);
      chk("bp full in_ready", 32'(d_ir[0]), 0);
      chk("bp stall 1", 32'(d_st[0]), 1);
      tick();
      drive(1, 1, 0, 0, 8'hC3, 16'h00C3);
      chk("bp stall 2", 32'(d_st[0]), 2);
      chk("bp still A", 32'(d_data[0]), 32'h00A1);
      chk("bp skid0 in_ready comb", 32'(d_ir[1]), 1);
      tick();
      drive(1, 1, 0, 0, 8'hC3, 16'h00C3);
      chk("bp B next", 32'(d_data[0]), 32'h00B2);
      tick();
      drive(0, 1, 0, 0, 8'h00, 16'h0000);
      chk("bp C next", 32'(d_data[0]), 32'h00C3);
      chk("bp C valid", 32'(d_ov[0]), 1);
      tick();
      drive(0, 1, 0, 0, 8'h00, 16'h0000); tick();

      // flush while full, D offered
      drive(1, 0, 0, 0, 8'hA4, 16'h0A44); tick();
      drive(1, 0, 0, 0, 8'hB5, 16'h0B55); tick();
      drive(1, 0, 1, 0, 8'hD6, 16'h0D66); tick();
      drive(0, 1, 0, 0, 8'h00, 16'h0000);
      chk("flush out_valid", 32'(d_ov[0]), 0);
      chk("flush out_ctrl", 32'(d_ctrl[0]), 0);
      chk("flush in_ready", 32'(d_ir[0]), 1);
      chk("flush data kept", 32'(d_data[0]), 32'h0A44);
      tick();

      // reset and flush together while busy
      drive(1, 1, 0, 0, 8'hE7, 16'h0E77); tick();
      drive(1, 0, 1, 1, 8'hF8, 16'h0F88); tick();
      drive(0, 1, 0, 0, 8'h00, 16'h0000);
      chk("rstfl out_valid", 32'(d_ov[0]), 0);
      chk("rstfl out_data", 32'(d_data[0]), 0);
      chk("rstfl stall", 32'(d_st[0]), 0);
      tick();

      // stall counter saturation
      drive(1, 0, 0, 0, 8'h99, 16'h0999); tick();
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0, 8'h00, 16'h0000); tick();
      end
      drive(0, 1, 0, 0, 8'h00, 16'h0000);
      chk("sat narrow", 32'(d_st[2]), 15);
      chk("sat wide", 32'(d_st[0]), 20);
      tick();
      drive(0, 1, 0, 0, 8'h00, 16'h0000); tick();

      // random traffic against the reference
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
               CW'($urandom), DW'($urandom));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
